// File: rtl/fetch_seq.sv
// Instruction fetch/execute sequencer for the 8-bit accumulator core.
// Owns the PC, the program-memory read port and the call/return stack.
module fetch_seq #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] pm_addr,
    output logic                  pm_rd_en,
    input  logic [7:0]            pm_data,
    input  logic                  stall,
    output logic [7:0]            instr,
    output logic [7:0]            operand,
    output logic                  exec,
    input  logic                  jmp_en,
    input  logic [1:0]            stack_control,
    input  logic                  soft_rst,
    output logic [1:0]            stack_flags,
    output logic                  stack_err,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {FETCH, LATCH_OP, LATCH_ARG, EXEC} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [SP_W-1:0]       sp;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic                  full, empty;
    logic                  push_req, pop_req;
    logic [IDX_W-1:0]      push_idx, pop_idx;
    logic [ADDR_WIDTH-1:0] operand_pc;

    function automatic logic has_operand(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h0A, 8'h0B, 8'h0C, 8'h0E, 8'h0F,
            8'h10, 8'h11, 8'h12: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    assign full        = (sp == SP_W'(STACK_DEPTH));
    assign empty       = (sp == '0);
    assign stack_flags = {full, empty};
    assign push_req    = (stack_control == 2'b10);
    assign pop_req     = (stack_control == 2'b01);
    assign push_idx    = sp[IDX_W-1:0];
    assign pop_idx     = IDX_W'(sp - 1'b1);
    assign operand_pc  = ADDR_WIDTH'(operand);
    assign pm_addr     = pc_q;
    assign pc          = pc_q;

    // Operand read is issued in the same cycle the opcode arrives, so it
    // must decode pm_data combinationally rather than the latched instr.
    assign pm_rd_en = rst_n && (((state == FETCH) && !stall) ||
                                ((state == LATCH_OP) && has_operand(pm_data)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc_q      <= RESET_VECTOR;
            sp        <= '0;
            instr     <= 8'h13;
            operand   <= 8'h00;
            exec      <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!stall) begin
                        pc_q  <= pc_q + 1'b1;
                        state <= LATCH_OP;
                    end
                end
                LATCH_OP: begin
                    instr <= pm_data;
                    if (has_operand(pm_data)) begin
                        pc_q  <= pc_q + 1'b1;
                        state <= LATCH_ARG;
                    end else begin
                        operand <= 8'h00;
                        exec    <= 1'b1;
                        state   <= EXEC;
                    end
                end
                LATCH_ARG: begin
                    operand <= pm_data;
                    exec    <= 1'b1;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (!stall) begin
                        exec  <= 1'b0;
                        state <= FETCH;
                        if ((instr == 8'h0C && full) || (instr == 8'h0D && empty))
                            stack_err <= 1'b1;
                        if (soft_rst) begin
                            pc_q <= RESET_VECTOR;
                            sp   <= '0;
                        end else if (pop_req) begin
                            if (!empty) begin
                                pc_q <= stack_mem[pop_idx];
                                sp   <= sp - 1'b1;
                            end
                        end else if (push_req) begin
                            // A call on a full stack still jumps; only the return address is lost.
                            if (!full) begin
                                stack_mem[push_idx] <= pc_q;
                                sp                  <= sp + 1'b1;
                            end
                            pc_q <= operand_pc;
                        end else if (jmp_en && has_operand(instr)) begin
                            pc_q <= operand_pc;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: ROM with registered read, small decoder model,
// per-scenario tasks with inline hand-computed expectations.
module tb_fetch_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pm_addr;
    logic       pm_rd_en;
    logic [7:0] pm_data;
    logic       stall;
    logic [7:0] instr;
    logic [7:0] operand;
    logic       exec;
    logic       jmp_en;
    logic [1:0] stack_control;
    logic       soft_rst;
    logic [1:0] stack_flags;
    logic       stack_err;
    logic [7:0] pc;

    logic [7:0] rom [256];
    logic       dec_soft;
    int         checks = 0;
    int         errors = 0;

    fetch_seq dut (
        .clk(clk), .rst_n(rst_n), .pm_addr(pm_addr), .pm_rd_en(pm_rd_en),
        .pm_data(pm_data), .stall(stall), .instr(instr), .operand(operand),
        .exec(exec), .jmp_en(jmp_en), .stack_control(stack_control),
        .soft_rst(soft_rst), .stack_flags(stack_flags), .stack_err(stack_err),
        .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (pm_rd_en) pm_data <= rom[pm_addr];

    // Decoder stand-in: JMP=0A, CLL=0C (push+jump), RET=0D (pop).
    always_comb begin
        jmp_en        = 1'b0;
        stack_control = 2'b00;
        soft_rst      = dec_soft;
        case (instr)
            8'h0A: jmp_en = 1'b1;
            8'h0C: begin jmp_en = 1'b1; stack_control = 2'b10; end
            8'h0D: stack_control = 2'b01;
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h13;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stall    = 1'b0;
        dec_soft = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_exec(output int n);
        n = 0;
        while (exec !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (exec !== 1'b1) begin
            errors++;
            $display("FAIL exec_timeout: exec=%b after %0d cycles, required 1", exec, n);
        end
    endtask

    task automatic test_reset();
        load_rom();
        rst_n = 1'b0; stall = 1'b0; dec_soft = 1'b0;
        tick();
        tick();
        checks++; if (instr !== 8'h13) begin errors++; $display("FAIL reset_instr: got %h required 13", instr); end
        checks++; if (operand !== 8'h00) begin errors++; $display("FAIL reset_operand: got %h required 00", operand); end
        checks++; if (exec !== 1'b0) begin errors++; $display("FAIL reset_exec: got %b required 0", exec); end
        checks++; if (pm_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", pm_rd_en); end
        checks++; if (stack_flags !== 2'b01) begin errors++; $display("FAIL reset_flags: got %b required 01", stack_flags); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", stack_err); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h required 00", pc); end
        rst_n = 1'b1;
    endtask

    task automatic test_straight();
        int n;
        load_rom();
        rom[0] = 8'h09; rom[1] = 8'h05; rom[2] = 8'h3C;
        do_reset();
        wait_exec(n);
        checks++; if (n + 1 !== 3) begin errors++; $display("FAIL straight_exec1_cycle: got %0d required 3", n + 1); end
        checks++; if (instr !== 8'h09 || operand !== 8'h00) begin errors++; $display("FAIL straight_instr1: got %h/%h required 09/00", instr, operand); end
        tick();
        wait_exec(n);
        checks++; if (n + 4 !== 7) begin errors++; $display("FAIL straight_exec2_cycle: got %0d required 7", n + 4); end
        checks++; if (instr !== 8'h05 || operand !== 8'h3C) begin errors++; $display("FAIL straight_instr2: got %h/%h required 05/3C", instr, operand); end
        tick();
        checks++; if (pc !== 8'h03) begin errors++; $display("FAIL straight_pc: got %h required 03", pc); end
        checks++; if (exec !== 1'b0) begin errors++; $display("FAIL straight_exec_one_cycle: got %b required 0", exec); end
    endtask

    task automatic test_jump();
        int n;
        load_rom();
        rom[0] = 8'h0A; rom[1] = 8'h20;
        do_reset();
        wait_exec(n);
        tick();
        checks++; if (pm_addr !== 8'h20 || pm_rd_en !== 1'b1) begin errors++; $display("FAIL jump_fetch: got addr %h rd %b required 20/1", pm_addr, pm_rd_en); end
    endtask

    task automatic test_call_ret();
        int n;
        load_rom();
        rom[0] = 8'h0C; rom[1] = 8'h40; rom[8'h40] = 8'h0D;
        do_reset();
        wait_exec(n);
        checks++; if (instr !== 8'h0C || operand !== 8'h40) begin errors++; $display("FAIL call_instr: got %h/%h required 0C/40", instr, operand); end
        tick();
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL call_pc: got %h required 40", pc); end
        checks++; if (stack_flags !== 2'b00) begin errors++; $display("FAIL call_flags: got %b required 00", stack_flags); end
        wait_exec(n);
        tick();
        checks++; if (pc !== 8'h02) begin errors++; $display("FAIL ret_pc: got %h required 02", pc); end
        checks++; if (stack_flags !== 2'b01) begin errors++; $display("FAIL ret_flags: got %b required 01", stack_flags); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ret_err: got %b required 0", stack_err); end
    endtask

    task automatic test_stack_limits();
        int n;
        logic [7:0] a;
        load_rom();
        for (int k = 0; k < 9; k++) begin
            a = 8'(2 * k);
            rom[a] = 8'h0C;
            rom[a + 8'd1] = a + 8'd2;
        end
        do_reset();
        for (int k = 0; k < 9; k++) begin
            wait_exec(n);
            tick();
            if (k == 7) begin
                checks++; if (stack_flags !== 2'b10) begin errors++; $display("FAIL full_after_8: got %b required 10", stack_flags); end
                checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL err_after_8: got %b required 0", stack_err); end
                checks++; if (pc !== 8'h10) begin errors++; $display("FAIL pc_after_8: got %h required 10", pc); end
            end
        end
        checks++; if (pc !== 8'h12) begin errors++; $display("FAIL ninth_call_pc: got %h required 12", pc); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL ninth_call_err: got %b required 1", stack_err); end
        checks++; if (stack_flags !== 2'b10) begin errors++; $display("FAIL ninth_call_flags: got %b required 10", stack_flags); end

        load_rom();
        rom[0] = 8'h0D;
        do_reset();
        wait_exec(n);
        tick();
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL empty_ret_pc: got %h required 01", pc); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL empty_ret_err: got %b required 1", stack_err); end
        checks++; if (stack_flags !== 2'b01) begin errors++; $display("FAIL empty_ret_flags: got %b required 01", stack_flags); end
    endtask

    task automatic test_stall_exec();
        int n;
        int cnt;
        load_rom();
        rom[0] = 8'h0A; rom[1] = 8'h20;
        do_reset();
        wait_exec(n);
        cnt = 1;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (exec === 1'b1) cnt++;
            checks++; if (pc !== 8'h02) begin errors++; $display("FAIL stall_pc_held: got %h required 02", pc); end
        end
        stall = 1'b0;
        checks++; if (cnt !== 4) begin errors++; $display("FAIL stall_exec_cycles: got %0d required 4", cnt); end
        tick();
        checks++; if (pc !== 8'h20 || exec !== 1'b0) begin errors++; $display("FAIL stall_release: got pc %h exec %b required 20/0", pc, exec); end
    endtask

    task automatic test_soft_rst();
        int n;
        load_rom();
        rom[0] = 8'h0C; rom[1] = 8'h40; rom[8'h40] = 8'h0A; rom[8'h41] = 8'h50;
        do_reset();
        wait_exec(n);
        tick();
        checks++; if (stack_flags !== 2'b00) begin errors++; $display("FAIL soft_pre_flags: got %b required 00", stack_flags); end
        wait_exec(n);
        dec_soft = 1'b1;
        tick();
        dec_soft = 1'b0;
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL soft_pc: got %h required 00", pc); end
        checks++; if (stack_flags !== 2'b01) begin errors++; $display("FAIL soft_sp: got %b required 01", stack_flags); end
    endtask

    task automatic test_mid_reset();
        int n;
        load_rom();
        rom[0] = 8'h0D; rom[1] = 8'h0A; rom[2] = 8'h20;
        do_reset();
        wait_exec(n);
        tick();
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL mid_pre_err: got %b required 1", stack_err); end
        tick();
        tick();
        checks++; if (instr !== 8'h0A) begin errors++; $display("FAIL mid_latch_op: got %h required 0A", instr); end
        rst_n = 1'b0;
        tick();
        checks++; if (instr !== 8'h13 || operand !== 8'h00) begin errors++; $display("FAIL mid_instr: got %h/%h required 13/00", instr, operand); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL mid_pc: got %h required 00", pc); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b required 0", stack_err); end
        rst_n = 1'b1;
        #1;
        checks++; if (pm_rd_en !== 1'b1 || pm_addr !== 8'h00) begin errors++; $display("FAIL mid_fetch: got rd %b addr %h required 1/00", pm_rd_en, pm_addr); end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; dec_soft = 1'b0;
        test_reset();
        test_straight();
        test_jump();
        test_call_ret();
        test_stack_limits();
        test_stall_exec();
        test_soft_rst();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction fetch/execute sequencer for the 8-bit accumulator core.
- Owns the program counter (PC), the program-memory read port and the hardware call/return stack.
- Presents one opcode plus optional operand byte to the instruction decoder, strobes execution, and applies the decoder's jmp_en, stack_control and soft-reset results to compute the next PC.

Parameters:
- ADDR_WIDTH, 8, PC / program-memory address width.
- STACK_DEPTH, 8, number of return-address entries (power of 2, >=2).
- RESET_VECTOR, 0, PC value after hard or soft reset.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- pm_addr  output  ADDR_WIDTH  program-memory address, always equal to PC.
- pm_rd_en  output  1  program-memory read strobe; data valid on pm_data the following cycle.
- pm_data  input  8  program-memory read data.
- stall  input  1  hold request from IO/memory.
- instr  output  8  latched opcode to decoder.
- operand  output  8  latched operand byte (0 for no-operand opcodes).
- exec  output  1  one-cycle execute strobe.
- jmp_en  input  1  from decoder.
- stack_control  input  2  from decoder, {push, pop}.
- soft_rst  input  1  decoder rst output.
- stack_flags  output  2  {full, empty}, to decoder.
- stack_err  output  1  sticky; set on push-when-full or pop-when-empty attempt.
- pc  output  ADDR_WIDTH  current PC, debug.

Behaviour:
- Reset (rst_n=0 at a clk edge) wins over everything, including mid-fetch:
  - PC=RESET_VECTOR, sp=0, state=FETCH.
  - instr=8'h13 (NOP), operand=0, exec=0, pm_rd_en=0, stack_flags=2'b01, stack_err=0.
- Operand-bearing opcodes: 01-05, 0A, 0B, 0C, 0E, 0F, 10, 11, 12.
- All other opcodes, including undefined ones, carry no operand.
- FSM states: FETCH, LATCH_OP, LATCH_ARG, EXEC.
- FETCH:
  - If stall=1: hold, pm_rd_en=0.
  - Else: pm_rd_en=1, PC<=PC+1, go to LATCH_OP.
- LATCH_OP:
  - instr<=pm_data.
  - If the opcode carries an operand: pm_rd_en=1 (combinational on pm_data), PC<=PC+1, go to LATCH_ARG.
  - Else: operand<=0, go to EXEC.
- LATCH_ARG: operand<=pm_data, go to EXEC.
- EXEC:
  - exec=1 for exactly one cycle; instr/operand held stable; decoder outputs sampled at the end of this cycle.
  - If stall=1: exec stays high and state holds, but the next-PC update is deferred until stall=0.
  - Then return to FETCH.
- Latency: 3 cycles per no-operand instruction, 4 per operand instruction, plus stall cycles.
- Next-PC priority, evaluated in the EXEC cycle with stall=0:
  - soft_rst: PC<=RESET_VECTOR, sp<=0; stack_err unchanged.
  - stack_control==2'b01 (pop) and not empty: PC<=stack[sp-1], sp<=sp-1.
  - stack_control==2'b10 (push) and not full: stack[sp]<=PC (return address, already past the operand), sp<=sp+1, PC<=operand.
  - jmp_en=1 and instr carries an operand: PC<=operand.
  - Otherwise: PC unchanged (sequential).
- stack_control==2'b11 is treated as 2'b00.
- stack_err is set when, in EXEC:
  - instr=0C and full=1 (the call still jumps; the return address is lost), or
  - instr=0D and empty=1 (the return falls through).
- stack_err clears only on rst_n.
- Operand to PC: zero-extended if ADDR_WIDTH>8, truncated if <8.
- PC increments wrap modulo 2^ADDR_WIDTH.
- stack_flags is combinational from sp: full=(sp==STACK_DEPTH), empty=(sp==0).
- pm_rd_en is never asserted outside FETCH and LATCH_OP; stall is ignored in LATCH_OP and LATCH_ARG.

Test Plan:
- Straight-line fetch: ROM[0]=09, ROM[1]=05, ROM[2]=3C. Required:
  - exec at cycles 3 and 7 after reset release.
  - instr=09 with operand=00, then instr=05 with operand=3C.
  - PC=3 after the second exec.
- Jump: ROM[0]=0A, ROM[1]=20; decoder drives jmp_en=1 in EXEC. Required: next pm_addr=8'h20 with pm_rd_en=1.
- Call/return:
  - ROM[0]=0C, ROM[1]=40, ROM[40]=0D. Required: push of 02, PC=40, flags=00.
  - Then RET with pop. Required: PC=02, flags=01, stack_err=0.
- Stack limits:
  - Nine consecutive CLLs with STACK_DEPTH=8. Required: full=1 after the 8th; the 9th still jumps and sets stack_err=1.
  - RET on an empty stack. Required: PC falls through and stack_err=1.
- Stall and soft reset:
  - stall=1 held 3 cycles during EXEC of 0A/20. Required: exec high 4 cycles, single PC update to 20.
  - soft_rst in EXEC. Required: PC=RESET_VECTOR, sp=0.
- Mid-operation reset: rst_n=0 during LATCH_ARG. Required: next cycle instr=13, operand=00, PC=0, state FETCH, stack_err=0.
